// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and widths for the multiply/divide unit.
// Op classification helpers keep decode identical across files.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int DLEN = 64;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MADD  = 3'd4;
    localparam logic [2:0] MADDU = 3'd5;
    localparam logic [2:0] MSUB  = 3'd6;
    localparam logic [2:0] MSUBU = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [2:0] code);
        return (code == DIV) || (code == DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] code);
        return (code == MULT) || (code == DIV) || (code == MADD) || (code == MSUB);
    endfunction

    function automatic logic op_is_accum(input logic [2:0] code);
        return (code == MADD) || (code == MADDU) || (code == MSUB) || (code == MSUBU);
    endfunction

    function automatic logic op_is_sub(input logic [2:0] code);
        return (code == MSUB) || (code == MSUBU);
    endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle after start.
// quotient/remainder present the final step combinationally in the done cycle.
module div_core
    import muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(DIV_ITER);
    localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

    logic            active;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    // Partial remainder always fits XLEN bits: it stays below the divisor.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = shifted >= {1'b0, dvs_q};
        rem_nxt = ge ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ge};
    end

    assign done      = active && (cnt == LAST);
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            quo_q  <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (active) begin
            if (abort || done) begin
                active <= 1'b0;
            end
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multi-cycle multiply/divide unit feeding the HI/LO register file.
// Define MULDIV_ACCUM_EN to accept MADD/MADDU/MSUB/MSUBU with multiply timing.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    input  logic [XLEN-1:0] hi_cur,
    input  logic [XLEN-1:0] lo_cur,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    state_t          state, state_nxt;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            q_neg_q, r_neg_q, dbz_q;
    logic            supported, accept, div_start, sdiv;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_done;
    logic [XLEN-1:0] div_quo, div_rem;
    logic [DLEN-1:0] ext_a, ext_b, prod, mul_res;
    logic [XLEN-1:0] quo_fix, rem_fix;
    logic            mul_load, div_load;

`ifdef MULDIV_ACCUM_EN
    logic [XLEN-1:0] hi_acc_q, lo_acc_q;

    assign supported = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_acc_q <= '0;
            lo_acc_q <= '0;
        end else if (accept) begin
            hi_acc_q <= hi_cur;
            lo_acc_q <= lo_cur;
        end
    end
`else
    logic unused_accum;

    assign supported    = !op_is_accum(op);
    assign unused_accum = ^{hi_cur, lo_cur};
`endif

    assign accept    = op_valid && (state == ST_IDLE) && !flush && supported;
    assign div_start = accept && op_is_div(op);
    assign sdiv      = (op == DIV);
    assign abs_a     = (sdiv && src_a[XLEN-1]) ? -src_a : src_a;
    assign abs_b     = (sdiv && src_b[XLEN-1]) ? -src_b : src_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= MULT;
            a_q     <= '0;
            b_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= op;
            a_q     <= src_a;
            b_q     <= src_b;
            q_neg_q <= sdiv && (src_a[XLEN-1] ^ src_b[XLEN-1]);
            r_neg_q <= sdiv && src_a[XLEN-1];
            dbz_q   <= (src_b == '0);
        end
    end

    div_core #(.DIV_ITER(DIV_ITER)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Sign/zero extension to 64 bits makes one modulo-2^64 multiply serve both signednesses.
    always_comb begin
        ext_a = op_is_signed(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
        ext_b = op_is_signed(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
        prod  = ext_a * ext_b;
`ifdef MULDIV_ACCUM_EN
        if (op_is_accum(op_q)) begin
            mul_res = op_is_sub(op_q) ? ({hi_acc_q, lo_acc_q} - prod)
                                      : ({hi_acc_q, lo_acc_q} + prod);
        end else begin
            mul_res = prod;
        end
`else
        mul_res = prod;
`endif
    end

    always_comb begin
        quo_fix = q_neg_q ? -div_quo : div_quo;
        rem_fix = r_neg_q ? -div_rem : div_rem;
        if (dbz_q) begin
            quo_fix = '1;
            rem_fix = a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = op_is_div(op) ? ST_DIV : ST_MUL;
            ST_MUL:  state_nxt = ST_IDLE;
            ST_DIV:  if (flush || div_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        mul_load = (state == ST_MUL) && !flush;
        div_load = (state == ST_DIV) && div_done && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_valid <= 1'b0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            result_valid <= mul_load || div_load;
            if (mul_load) begin
                hi_o <= mul_res[DLEN-1:XLEN];
                lo_o <= mul_res[XLEN-1:0];
            end else if (div_load) begin
                hi_o <= rem_fix;
                lo_o <= quo_fix;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model checked every cycle,
// directed cases with literal results, then randomized traffic with flush/reset.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, op_valid, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, hi_cur, lo_cur;
    logic        busy, result_valid;
    logic [31:0] hi_o, lo_o;

    mul_div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .hi_cur       (hi_cur),
        .lo_cur       (lo_cur),
        .busy         (busy),
        .result_valid (result_valid),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_supported(input logic [2:0] code);
`ifdef MULDIV_ACCUM_EN
        return 1'b1;
`else
        return code <= 3'd3;
`endif
    endfunction

    function automatic int ref_lat(input logic [2:0] code);
        return (code == 3'd2 || code == 3'd3) ? 32 : 1;
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] code, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hc,
                                               input logic [31:0] lc);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib, iq, ir;
        logic [31:0]     q32, r32;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (code == 3'd2 || code == 3'd3) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (code == 3'd3) begin
                q32 = a / b;
                r32 = a % b;
                return {r32, q32};
            end
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            ia = a;
            ib = b;
            iq = ia / ib;
            ir = ia % ib;
            q32 = iq;
            r32 = ir;
            return {r32, q32};
        end
        p = (code == 3'd1 || code == 3'd5 || code == 3'd7) ? ua * ub : sa * sb;
        if (code == 3'd4 || code == 3'd5) return {hc, lc} + p;
        if (code == 3'd6 || code == 3'd7) return {hc, lc} - p;
        return p;
    endfunction

    bit          started = 0;
    bit          pend = 0;
    int          busy_lo = 0, busy_hi = -1, due = -1;
    logic [63:0] pend_res = '0, m_res = '0;

    always @(negedge clk) begin : model
        bit exp_valid, exp_busy;
        exp_valid = 0;
        if (pend && cyc == due) begin
            m_res     = pend_res;
            exp_valid = 1;
            pend      = 0;
        end
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        if (started) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("result_valid", {31'd0, result_valid}, {31'd0, exp_valid});
            chk("hi_o", hi_o, m_res[63:32]);
            chk("lo_o", lo_o, m_res[31:0]);
        end
        if (rst) begin
            started = 1;
            pend    = 0;
            busy_hi = -1;
            m_res   = '0;
        end else if (exp_busy && flush) begin
            busy_hi = cyc;
            pend    = 0;
        end else if (!exp_busy && op_valid && !flush && ref_supported(op)) begin
            busy_lo  = cyc + 1;
            busy_hi  = cyc + ref_lat(op);
            due      = cyc + ref_lat(op) + 1;
            pend     = 1;
            pend_res = ref_result(op, src_a, src_b, hi_cur, lo_cur);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic directed(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eh, input logic [31:0] el, input int lat,
                            input string nm);
        int t0;
        bit got;
        got = 0;
        @(posedge clk); #1;
        op_valid = 1; op = code; src_a = a; src_b = b; t0 = cyc;
        @(posedge clk); #1;
        op_valid = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (result_valid) begin
                got = 1;
                chk({nm, "_lat"}, cyc - t0, lat + 1);
                chk({nm, "_hi"}, hi_o, eh);
                chk({nm, "_lo"}, lo_o, el);
                chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
            end else if (cyc > t0) begin
                chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
            end
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, tv, npulse;
        rst = 1; op_valid = 0; flush = 0; op = 3'd0;
        src_a = 0; src_b = 0; hi_cur = 0; lo_cur = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);

        directed(MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "mult");
        directed(MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1, "multu");
        directed(DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, "div_neg");
        directed(DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 32, "divu");
        directed(DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32, "divu_zero");
        directed(DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32, "div_zero");
        directed(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32, "div_ovf");
        directed(DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32, "div_pos_neg");

`ifdef MULDIV_ACCUM_EN
        hi_cur = 32'd0; lo_cur = 32'hFFFF_FFFF;
        directed(MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 1, "maddu");
        hi_cur = 32'd0; lo_cur = 32'd0;
        directed(MSUB, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1, "msub");
`else
        @(posedge clk); #1;
        op_valid = 1; op = 3'd4; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        op_valid = 0;
        @(negedge clk);
        chk("undef_busy", {31'd0, busy}, 32'd0);
        npulse = 0;
        repeat (5) begin
            @(negedge clk);
            if (result_valid) npulse++;
        end
        chk("undef_pulses", npulse, 0);
`endif

        // flush mid-divide, then a multiply right behind it
        @(posedge clk); #1;
        op_valid = 1; op = DIV; src_a = 32'd1000; src_b = 32'd3; t0 = cyc;
        @(posedge clk); #1;
        op_valid = 0;
        while (cyc < t0 + 10) begin
            @(posedge clk); #1;
        end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        op_valid = 1; op = MULT; src_a = 32'd3; src_b = 32'd5; t1 = cyc;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        op_valid = 0;
        npulse = 0; tv = -1;
        while (cyc <= t0 + 40) begin
            @(negedge clk);
            if (result_valid) begin
                npulse++;
                tv = cyc;
                chk("flush_mul_lo", lo_o, 32'd15);
                chk("flush_mul_hi", hi_o, 32'd0);
            end
        end
        chk("flush_pulses", npulse, 1);
        chk("flush_mul_lat", tv - t1, 2);

        // op_valid held while busy must not start a second operation
        @(posedge clk); #1;
        op_valid = 1; op = DIVU; src_a = 32'd1000; src_b = 32'd7; t0 = cyc;
        @(posedge clk); #1;
        op = MULT; src_a = 32'd9; src_b = 32'd9;
        repeat (32) @(posedge clk);
        #1 op_valid = 0;
        npulse = 0;
        while (cyc <= t0 + 45) begin
            @(negedge clk);
            if (result_valid) begin
                npulse++;
                chk("hold_lo", lo_o, 32'd142);
                chk("hold_hi", hi_o, 32'd6);
            end
        end
        chk("hold_pulses", npulse, 1);

        // reset in the middle of a divide
        @(posedge clk); #1;
        op_valid = 1; op = DIV; src_a = 32'd12345; src_b = 32'd17;
        @(posedge clk); #1;
        op_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, result_valid}, 32'd0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        repeat (40) @(posedge clk);

        // randomized traffic, checked cycle by cycle by the model
        repeat (3000) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 59) == 0);
            op_valid = ($urandom_range(0, 2) != 0);
            op       = 3'($urandom_range(0, 7));
            src_a    = pick();
            src_b    = pick();
            hi_cur   = $urandom;
            lo_cur   = $urandom;
        end
        @(posedge clk); #1;
        rst = 0; flush = 0; op_valid = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide execution unit in the EX stage, directly upstream of the HI/LO register file.
- Accepts one MULT/MULTU/DIV/DIVU (optionally MADD/MSUB family) operation at a time and computes a 64-bit {hi,lo} result.
- Emits the result with a one-cycle valid pulse that drives the HI/LO write enable.
- Busy output stalls the pipeline while an operation is in flight.

Parameters:
- DIV_ITER, 32, radix-2 divide iterations; fixed at operand width, not intended to be overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- op_valid  in  1  operation request this cycle
- op  in  3  operation code (package constants)
- src_a  in  32  rs operand / dividend
- src_b  in  32  rt operand / divisor
- flush  in  1  pipeline flush; abort in-flight op
- hi_cur  in  32  current HI value (accumulate ops only)
- lo_cur  in  32  current LO value (accumulate ops only)
- busy  out  1  operation in flight; upstream must hold
- result_valid  out  1  one-cycle pulse; drives HI/LO write_enable
- hi_o  out  32  result for HI (HI/LO hi_i)
- lo_o  out  32  result for LO (HI/LO lo_i)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst): state=IDLE, busy=0, result_valid=0, hi_o=0, lo_o=0, all internal operand and iteration registers cleared.
- States:
  - IDLE: busy=0.
  - MUL: 1 cycle.
  - DIV: DIV_ITER cycles.
- busy = (state != IDLE). hi_o, lo_o and result_valid are registered.
- Accept: op_valid && state==IDLE && !flush, at cycle T. Operands are latched at T. hi_cur/lo_cur are sampled at T.
- op_valid while busy is ignored.
- MULT/MULTU: product registered during MUL (T+1). result_valid=1 at T+2, state=IDLE at T+2. A new op may be accepted at T+2.
- DIV/DIVU:
  - At T, latch absolute values (signed) or raw values (unsigned), plus the quotient and remainder signs.
  - Restoring iterations run in T+1..T+32.
  - Sign fixup is applied when the result is registered.
  - result_valid=1 at T+33: lo_o=quotient, hi_o=remainder.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Divide by zero: no exception, same latency. lo_o=32'hFFFFFFFF, hi_o=src_a, for both signed and unsigned.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0.
- result_valid is exactly one cycle. hi_o/lo_o hold their last value until the next result.
- flush in MUL or DIV: state→IDLE next cycle; result_valid stays 0 and hi_o/lo_o are unchanged.
- flush concurrent with op_valid: the op is dropped.
- flush during the cycle result_valid is already high does not retract that pulse.
- rst mid-operation: same as reset; no result produced.
- Undefined op codes: not accepted, busy stays 0.

Optional Feature:
- Macro MULDIV_ACCUM_EN.
- Defined: op codes MADD/MADDU/MSUB/MSUBU are accepted with the MUL timing (result_valid at T+2).
  - {hi_o,lo_o} = {hi_cur,lo_cur} ± product, modulo 2^64.
  - Product is signed for MADD/MSUB, unsigned for MADDU/MSUBU.
- Not defined: these codes are treated as undefined (ignored). hi_cur/lo_cur ports remain present but unused.

Decomposition:
- Package muldiv_pkg:
  - op code constants: MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7.
  - state encoding for IDLE/MUL/DIV.
  - localparams for the 32/64-bit widths.
- One sub-module, div_core: the iterative restoring divider (start, dividend, divisor → done, quotient, remainder, unsigned only).
- Signed handling and the multiplier stay in mul_div_unit.

Test Plan:
- MULT 0xFFFFFFFF × 0x00000002 accepted at T → result_valid only at T+2; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. MULTU same operands → hi_o=0x00000001, lo_o=0xFFFFFFFE.
- DIV −7 ÷ 2 (0xFFFFFFF9, 0x2) → busy T+1..T+32, result_valid at T+33; lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100 ÷ 7 → lo_o=14, hi_o=2.
- Boundaries:
  - DIVU 5 ÷ 0 → lo_o=0xFFFFFFFF, hi_o=5 at T+33.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- Flush:
  - DIV accepted, flush at T+10 → busy=0 at T+11, no result_valid through T+40.
  - A new MULT accepted at T+11 → result at T+13.
- Backpressure and reset:
  - op_valid held during DIV busy → ignored, exactly one result_valid pulse.
  - rst asserted mid-DIV → all outputs 0 the next cycle.
- With MULDIV_ACCUM_EN: hi_cur=0, lo_cur=0xFFFFFFFF, MADDU 1×1 → hi_o=1, lo_o=0 at T+2.
- Without MULDIV_ACCUM_EN: op=4 → busy=0, no result_valid.
